// File: rtl/rotary_pkg.sv
// Shared constants and types for the rotary encoder decoder.
package rotary_pkg;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  typedef enum logic {
    ARM_SETTLE = 1'b0,
    ARM_ARMED  = 1'b1
  } arm_state_e;

endpackage

// File: rtl/input_filter.sv
// Metastability synchroniser followed by a consecutive-cycle debounce filter
// for one raw encoder pin.
module input_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   raw_s;

  assign raw_s = sync_q[SYNC_STAGES-1];

  // Filtered value only follows after FILTER_CYCLES consecutive disagreements.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d  = '0;
    filt_d = filt_q;
    if (raw_s != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        filt_d = raw_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder decoder: debounced detent detection, direction,
// and a wrapping or saturating position counter.
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned POS_WIDTH     = 8,
  parameter int unsigned STEP          = 1,
  parameter int unsigned SATURATE      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rot_a,
  input  logic                 rot_b,
  input  logic                 clear_pos,
  output logic                 rotation_event,
  output logic                 step_valid,
  output logic                 step_dir,
  output logic [POS_WIDTH-1:0] position,
  output logic                 limit_hit
);

  localparam int unsigned SETTLE_CYCLES = SYNC_STAGES + FILTER_CYCLES + 1;
  localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [POS_WIDTH-1:0] STEP_P  = POS_WIDTH'(STEP);
  localparam logic [POS_WIDTH-1:0] POS_MAX = '1;

  logic a_f, b_f;

  input_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (rot_a),
    .filt_o(a_f)
  );

  input_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (rot_b),
    .filt_o(b_f)
  );

  arm_state_e            arm_state_q, arm_state_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic                  evt_q, evt_d;
  logic                  evt_dly_q;
  logic                  dir_q, dir_d;
  logic                  step_valid_q, step_valid_d;
  logic                  step_dir_q, step_dir_d;
  logic [POS_WIDTH-1:0]  position_q, position_d;
  logic                  limit_hit_q, limit_hit_d;

  logic                  rise_c;
  logic                  step_c;
  logic                  up_c;
  logic [POS_WIDTH:0]    sum_up_c;
  logic                  under_c;

  // Arming: wait out the pipeline fill, then require the encoder to be seen at rest.
  always_comb begin
    arm_state_d  = arm_state_q;
    settle_cnt_d = settle_cnt_q;
    case (arm_state_q)
      ARM_SETTLE: begin
        if (settle_cnt_q != SETTLE_W'(SETTLE_CYCLES)) begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end else if (!evt_q) begin
          arm_state_d = ARM_ARMED;
        end
      end
      ARM_ARMED: begin
        arm_state_d = ARM_ARMED;
      end
    endcase
  end

  always_comb begin
    evt_d = evt_q;
    if (a_f && b_f) begin
      evt_d = 1'b1;
    end else if (!a_f && !b_f) begin
      evt_d = 1'b0;
    end
    dir_d = dir_q;
    if (!a_f && b_f) begin
      dir_d = 1'b1;
    end else if (a_f && !b_f) begin
      dir_d = 1'b0;
    end
  end

  assign rise_c   = evt_q & ~evt_dly_q;
  assign step_c   = rise_c & (arm_state_q == ARM_ARMED);
  assign up_c     = ~dir_q;
  assign sum_up_c = {1'b0, position_q} + {1'b0, STEP_P};
  assign under_c  = (position_q < STEP_P);

  // Step pulse and position update; clear_pos overrides any step result.
  always_comb begin
    step_valid_d = step_c;
    step_dir_d   = step_dir_q;
    position_d   = position_q;
    limit_hit_d  = 1'b0;
    if (step_c) begin
      step_dir_d = up_c ? DIR_CW : DIR_CCW;
      if (up_c) begin
        if ((SATURATE == MODE_SAT) && sum_up_c[POS_WIDTH]) begin
          position_d  = POS_MAX;
          limit_hit_d = 1'b1;
        end else begin
          position_d = sum_up_c[POS_WIDTH-1:0];
        end
      end else begin
        if ((SATURATE == MODE_SAT) && under_c) begin
          position_d  = '0;
          limit_hit_d = 1'b1;
        end else begin
          position_d = position_q - STEP_P;
        end
      end
    end
    if (clear_pos) begin
      position_d  = '0;
      limit_hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm_state_q  <= ARM_SETTLE;
      settle_cnt_q <= '0;
      evt_q        <= 1'b0;
      evt_dly_q    <= 1'b0;
      dir_q        <= 1'b0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      position_q   <= '0;
      limit_hit_q  <= 1'b0;
    end else begin
      arm_state_q  <= arm_state_d;
      settle_cnt_q <= settle_cnt_d;
      evt_q        <= evt_d;
      evt_dly_q    <= evt_q;
      dir_q        <= dir_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      position_q   <= position_d;
      limit_hit_q  <= limit_hit_d;
    end
  end

  assign rotation_event = evt_q;
  assign step_valid     = step_valid_q;
  assign step_dir       = step_dir_q;
  assign position       = position_q;
  assign limit_hit      = limit_hit_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: a wrap-mode and a saturate-mode instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_rotary_decoder;

  localparam int S        = 2;
  localparam int F        = 4;
  localparam int SETTLE   = S + F + 1;
  localparam int SAT_STEP = 100;

  logic clk = 1'b0;
  logic rst_n, rot_a, rot_b, clear_pos;
  logic w_ev, w_sv, w_sd, w_lim;
  logic [7:0] w_pos;
  logic s_ev, s_sv, s_sd, s_lim;
  logic [7:0] s_pos;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int w_steps = 0;
  int s_lims  = 0;

  always #5 clk = ~clk;

  rotary_decoder u_wrap (
    .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .clear_pos(clear_pos),
    .rotation_event(w_ev), .step_valid(w_sv), .step_dir(w_sd),
    .position(w_pos), .limit_hit(w_lim)
  );

  rotary_decoder #(
    .SYNC_STAGES(S), .FILTER_CYCLES(F), .POS_WIDTH(8), .STEP(SAT_STEP), .SATURATE(1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .rot_a(rot_a), .rot_b(rot_b), .clear_pos(clear_pos),
    .rotation_event(s_ev), .step_valid(s_sv), .step_dir(s_sd),
    .position(s_pos), .limit_hit(s_lim)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw pin history since reset, filtered values derived
  // from "F consecutive synchronised samples disagree" over that history.
  bit ha[$], hb[$];
  int n;
  bit m_af, m_bf, m_ev, m_evd, m_dir, m_armed, m_sv, m_sd, m_lw, m_ls;
  int m_pw, m_ps;
  bit af0, bf0, ev0, evd0, dir0, arm0, stp;

  function automatic bit synced(input bit h[$], input int e);
    return (e - S >= 1) ? h[e - S - 1] : 1'b0;
  endfunction

  function automatic bit settled(input bit h[$], input int e, input bit f);
    if (e < F) return 1'b0;
    for (int m = e - F + 1; m <= e; m++) begin
      if (synced(h, m) == f) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      ha.delete();
      hb.delete();
      m_af = 0; m_bf = 0; m_ev = 0; m_evd = 0; m_dir = 0; m_armed = 0;
      m_sv = 0; m_sd = 0; m_lw = 0; m_ls = 0; m_pw = 0; m_ps = 0;
    end else begin
      n++;
      ha.push_back(rot_a);
      hb.push_back(rot_b);
      af0 = m_af; bf0 = m_bf; ev0 = m_ev; evd0 = m_evd; dir0 = m_dir; arm0 = m_armed;
      if (settled(ha, n, af0)) m_af = ~af0;
      if (settled(hb, n, bf0)) m_bf = ~bf0;
      if (af0 && bf0) m_ev = 1'b1;
      else if (!af0 && !bf0) m_ev = 1'b0;
      if (!af0 && bf0) m_dir = 1'b1;
      else if (af0 && !bf0) m_dir = 1'b0;
      m_evd = ev0;
      stp = ev0 && !evd0 && arm0;
      if (!arm0 && (n - 1) >= SETTLE && !ev0) m_armed = 1'b1;
      m_sv = stp;
      m_lw = 1'b0;
      m_ls = 1'b0;
      if (stp) begin
        m_sd = !dir0;
        if (!dir0) begin
          m_pw = (m_pw + 1) % 256;
          m_ps = m_ps + SAT_STEP;
          if (m_ps > 255) begin m_ps = 255; m_ls = 1'b1; end
        end else begin
          m_pw = (m_pw + 255) % 256;
          m_ps = m_ps - SAT_STEP;
          if (m_ps < 0) begin m_ps = 0; m_ls = 1'b1; end
        end
      end
      if (clear_pos) begin
        m_pw = 0; m_ps = 0; m_ls = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("wrap_event", int'(w_ev), int'(m_ev));
      check_eq("sat_event", int'(s_ev), int'(m_ev));
      check_eq("wrap_valid", int'(w_sv), int'(m_sv));
      check_eq("sat_valid", int'(s_sv), int'(m_sv));
      if (m_sv) begin
        check_eq("wrap_dir", int'(w_sd), int'(m_sd));
        check_eq("sat_dir", int'(s_sd), int'(m_sd));
      end
      check_eq("wrap_pos", int'(w_pos), m_pw);
      check_eq("sat_pos", int'(s_pos), m_ps);
      check_eq("wrap_limit", int'(w_lim), int'(m_lw));
      check_eq("sat_limit", int'(s_lim), int'(m_ls));
      if (w_sv) w_steps++;
      if (s_lim) s_lims++;
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_ab(input bit a, input bit b, input int hold);
    rot_a = a;
    rot_b = b;
    cyc(hold);
  endtask

  task automatic cw_detent(input int h);
    set_ab(1, 0, h); set_ab(1, 1, h); set_ab(0, 1, h); set_ab(0, 0, h);
  endtask

  task automatic ccw_detent(input int h);
    set_ab(0, 1, h); set_ab(1, 1, h); set_ab(1, 0, h); set_ab(0, 0, h);
  endtask

  int base, lbase, lat, idx, r;
  bit [1:0] gray [4];

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
    rst_n = 1'b0; rot_a = 1'b0; rot_b = 1'b0; clear_pos = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    cyc(3);
    #1;
    check_eq("reset_pos", int'(w_pos), 0);
    check_eq("reset_valid", int'(w_sv), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(20);

    // CW detent with latency measurement from the 11 edge
    base = w_steps;
    set_ab(1, 0, 10);
    rot_a = 1'b1; rot_b = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (w_sv && lat == 0) lat = i;
    end
    set_ab(0, 1, 10); set_ab(0, 0, 10);
    #1;
    check_eq("cw_latency", lat, S + F + 2);
    check_eq("cw_steps", w_steps - base, 1);
    check_eq("cw_pos", int'(w_pos), 1);

    // CCW detents, wrapping below zero
    base = w_steps;
    ccw_detent(10);
    ccw_detent(10);
    #1;
    check_eq("ccw_steps", w_steps - base, 2);
    check_eq("ccw_wrap_pos", int'(w_pos), 255);

    // Short glitch on A must be filtered out
    base = w_steps;
    set_ab(1, 0, 3);
    set_ab(0, 0, 15);
    #1;
    check_eq("glitch_steps", w_steps - base, 0);
    check_eq("glitch_pos", int'(w_pos), 255);

    // Saturation at both ends
    lbase = s_lims;
    repeat (4) cw_detent(10);
    #1;
    check_eq("sat_hi_pos", int'(s_pos), 255);
    check_eq("sat_hi_limits", s_lims - lbase, 2);
    check_eq("wrap_after_hi", int'(w_pos), 3);
    repeat (3) ccw_detent(10);
    #1;
    check_eq("sat_lo_pos", int'(s_pos), 0);
    check_eq("sat_lo_limits", s_lims - lbase, 3);

    // clear_pos coinciding with a CW step
    repeat (5) cw_detent(10);
    #1;
    check_eq("pre_clear_pos", int'(w_pos), 5);
    set_ab(1, 0, 10);
    rot_a = 1'b1; rot_b = 1'b1;
    cyc(7);
    clear_pos = 1'b1;
    cyc(1);
    clear_pos = 1'b0;
    check_eq("clr_valid", int'(w_sv), 1);
    check_eq("clr_dir", int'(w_sd), 1);
    check_eq("clr_pos", int'(w_pos), 0);
    check_eq("clr_limit", int'(w_lim), 0);
    check_eq("clr_sat_limit", int'(s_lim), 0);
    check_eq("clr_sat_pos", int'(s_pos), 0);
    cyc(2);
    set_ab(0, 1, 10); set_ab(0, 0, 10);

    // Reset while resting at 11 must not produce a step
    rst_n = 1'b0; rot_a = 1'b1; rot_b = 1'b1;
    cyc(5);
    base = w_steps;
    rst_n = 1'b1;
    cyc(30);
    #1;
    check_eq("rest11_steps", w_steps - base, 0);
    set_ab(0, 0, 10);
    cw_detent(10);
    #1;
    check_eq("post_rest_steps", w_steps - base, 1);
    check_eq("post_rest_pos", int'(w_pos), 1);
    check_eq("post_rest_sat_pos", int'(s_pos), SAT_STEP);

    // Randomised rotation with bounces, jumps and clears
    idx = 0;
    repeat (300) begin
      r = int'($urandom_range(0, 19));
      if (r < 8) idx = (idx + 1) % 4;
      else if (r < 16) idx = (idx + 3) % 4;
      else if (r < 18) idx = (idx + 2) % 4;
      rot_a = gray[idx][1];
      rot_b = gray[idx][0];
      if ($urandom_range(0, 15) == 0) clear_pos = 1'b1;
      cyc(1);
      clear_pos = 1'b0;
      cyc(int'($urandom_range(0, 11)));
    end

    // Reset in the middle of a detent discards partial state
    set_ab(1, 0, 10);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    set_ab(0, 0, 30);
    base = w_steps;
    cw_detent(10);
    #1;
    check_eq("midreset_steps", w_steps - base, 1);
    check_eq("midreset_pos", int'(w_pos), 1);

    cyc(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
